// File: rtl/alu_result_queue.sv
// ----------------------------------------------------------------------------
// alu_result_queue
//
// Purpose:
//   Small circular FIFO that sits directly behind the 16-bit ALU. It captures
//   each valid result (Y, opcode tag and C/V/N/Z flags) with a valid/ready
//   handshake so that a stalling consumer (writeback, bus master) never loses
//   a result. A sticky flag register accumulates the flags of every accepted
//   result until software clears it.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  result width
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (push when both high)
//   in_y, in_op         ALU result and the opcode that produced it
//   in_c/v/n/z          ALU flags
//   out_valid/out_ready downstream handshake (pop when both high)
//   out_y, out_op       head entry result and opcode
//   out_flags           head entry flags {C,V,N,Z}
//   sticky_flags        OR of flags of all pushes since the last clear
//   sticky_clr          synchronous clear of sticky_flags
//   count               current occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_y,
    input  logic [2:0]                 in_op,
    input  logic                       in_c,
    input  logic                       in_v,
    input  logic                       in_n,
    input  logic                       in_z,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_y,
    output logic [2:0]                 out_op,
    output logic [3:0]                 out_flags,
    output logic [3:0]                 sticky_flags,
    input  logic                       sticky_clr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Entry layout: {y, op, c, v, n, z}
    localparam int EW = WIDTH + 7;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1'b1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [3:0]    sticky_r;

    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [3:0]    sticky_nxt_s;
    logic [3:0]    in_flags_s;
    logic [EW-1:0] head_s;
    logic          in_ready_s;
    logic          out_valid_s;
    logic          push_s;
    logic          pop_s;

    // Pack the four ALU flags in {C,V,N,Z} order
    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic n, input logic z);
        return {c, v, n, z};
    endfunction

    assign in_flags_s = pack_flags(in_c, in_v, in_n, in_z);

    // Handshake qualifiers come only from the count register, so there is no
    // combinational path from out_ready to in_ready and a full queue refuses
    // a push even when a pop happens in the same cycle.
    assign in_ready_s  = (count_r != COUNT_FULL);
    assign out_valid_s = (count_r != COUNT_ZERO);
    assign push_s      = in_valid & in_ready_s;
    assign pop_s       = out_valid_s & out_ready;

    assign head_s       = mem_r[rd_ptr_r];
    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_s;
    assign out_y        = head_s[EW-1 -: WIDTH];
    assign out_op       = head_s[6:4];
    assign out_flags    = head_s[3:0];
    assign count        = count_r;
    assign sticky_flags = sticky_r;

    // Next-state for pointers, occupancy and sticky flags
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        sticky_nxt_s = sticky_r;

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + COUNT_ONE;
            2'b01:   count_nxt_s = count_r - COUNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // Clear acts first, then the flags of a same-cycle push are ORed in
        if (sticky_clr) begin
            sticky_nxt_s = 4'b0000;
        end else begin
            sticky_nxt_s = sticky_r;
        end
        if (push_s) begin
            sticky_nxt_s = sticky_nxt_s | in_flags_s;
        end else begin
            sticky_nxt_s = sticky_nxt_s;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= COUNT_ZERO;
            sticky_r <= 4'b0000;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            sticky_r <= sticky_nxt_s;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_y, in_op, in_flags_s};
        end
    end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Buffers the combinational outputs of the 16-bit ALU (result Y, flags C/V/N/Z, and the opcode that produced them) into a small FIFO with a valid/ready handshake. Downstream consumers, such as writeback or a bus master, can stall without the issue side losing results. The block sits directly downstream of the ALU and also keeps a sticky condition-flag register that software clears explicitly.

## Interface
Parameters:
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- WIDTH, 16: result width; matches the ALU datapath.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU output is a valid result this cycle.
- in_ready  output  1  queue can accept an entry this cycle.
- in_y  input  WIDTH  ALU result Y.
- in_op  input  3  opcode that produced the result (tag).
- in_c, in_v, in_n, in_z  input  1 each  ALU flags.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_y  output  WIDTH  head result.
- out_op  output  3  head opcode.
- out_flags  output  4  head flags, packed {C,V,N,Z}.
- sticky_flags  output  4  OR of the flags of all accepted entries since the last clear, packed {C,V,N,Z}.
- sticky_clr  input  1  synchronous clear of sticky_flags.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries, each {y, op, c, v, n, z}.
  - Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate register.
- Push: occurs when in_valid && in_ready. The entry is written at the write pointer, which then increments.
- Pop: occurs when out_valid && out_ready. The read pointer increments.
- in_ready = (count != DEPTH).
  - Depends only on registered state; no combinational path from out_ready.
- out_valid = (count != 0).
  - out_y, out_op and out_flags are read combinationally from the head entry.
  - They hold stable while out_valid && !out_ready.
- Simultaneous push and pop (count in 1..DEPTH-1): both pointers advance and count is unchanged.
- When full, push cannot occur, even if a pop occurs in the same cycle. When empty, pop cannot occur.
  - There is no bypass: an entry pushed into an empty queue is not visible on the same cycle.
- in_valid while in_ready is low: nothing is written. The upstream side holds its inputs; the queue does not drop or overwrite.
- Output data is unspecified (but stable) while out_valid = 0.
- Sticky flags:
  - On a push, sticky_flags <= sticky_flags | {in_c,in_v,in_n,in_z}.
  - sticky_clr alone: sticky_flags <= 0.
  - sticky_clr together with a push in the same cycle: sticky_flags <= {in_c,in_v,in_n,in_z}. The clear takes effect first, then the new flags are ORed in.
  - A pop never affects sticky_flags.
- Reset (asserted at any time, including mid-transfer):
  - Pointers, count and sticky_flags go to 0 immediately.
  - All queued entries are discarded. Entry storage need not be reset.
  - Resulting outputs: out_valid=0, in_ready=1, count=0, sticky_flags=0.

## Timing
- Latency: a push at rising edge t makes the entry visible on out_* (out_valid=1) from just after edge t, when the queue was empty.
- A pop at edge t presents the next entry just after t.
- Full-rate streaming: one push and one pop per cycle is sustained indefinitely at any count in 1..DEPTH-1.
- in_ready falls in the cycle after the push that makes count=DEPTH. It rises in the cycle after the first pop from full.
- count, sticky_flags, in_ready and out_valid change only on clock edges or on asynchronous reset assertion.
- Reset release: the first push is accepted on the first rising edge after rst_n goes high.

## Test plan
- Reset, then push ADD result Y=0x0000 {C=1,V=0,N=0,Z=1}, op=000, with out_ready=0.
  - Next cycle: out_valid=1, out_y=0x0000, out_flags=4'b1001, count=1, sticky_flags=4'b1001.
- Push 0x0001, 0x0002, 0x0003, 0x0004 with out_ready=0.
  - in_ready=0 after the fourth push, count=4.
  - A fifth in_valid cycle is not accepted.
  - Then out_ready=1 for 4 cycles: out_y sequence is 0x0001..0x0004 and count returns to 0.
- Continuous streaming, in_valid=out_ready=1 for 20 cycles with Y=incrementing from 0x7FFE.
  - Output order is preserved with no gaps after the first cycle.
  - count stays 1.
  - Pointers wrap correctly past DEPTH.
- Sticky behaviour:
  - Push V=1 (0x7FFF+1 → 0x8000, {0,1,1,0}), then push 0x0001 {0,0,0,0}: sticky_flags=4'b0110.
  - Assert sticky_clr with a push of {1,0,0,0}: sticky_flags=4'b1000.
  - sticky_clr alone: sticky_flags=0.
- Mid-operation reset: with count=3 and out_valid=1, pulse rst_n low between clock edges.
  - Immediately: out_valid=0, count=0, in_ready=1, sticky_flags=0.
  - After release, the next push is the first output.
- Random backpressure: 1000 cycles with random in_valid and out_ready, checked against a scoreboard model.
  - Order, data and flags match.
  - No push is accepted while full and no pop occurs while empty.
